// File: rtl/evt2_uart_streamer.sv
// Streams EVT2.0 words MSB-first to a byte UART, injects commands between words
// and decodes classifier replies. Optional live counters: EVT2_STREAM_STATS_EN.
module evt2_uart_streamer #(
    parameter int RESP_TIMEOUT = 120000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] evt_word,
    input  logic        evt_valid,
    output logic        evt_ready,
    input  logic [1:0]  cmd_code,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [1:0]  gesture,
    output logic [3:0]  gesture_conf,
    output logic [3:0]  gesture_cnt_hi,
    output logic        gesture_valid,
    output logic        echo_ok,
    output logic [7:0]  status_byte,
    output logic        status_valid,
    output logic [7:0]  cfg_min_thresh,
    output logic [7:0]  cfg_motion_thresh,
    output logic        cfg_valid,
    output logic        cmd_timeout,
    output logic [15:0] stat_words_sent,
    output logic [15:0] stat_words_dropped,
    output logic [15:0] stat_rx_unexpected
);
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [1:0] K_ECHO   = 2'd0;
    localparam logic [1:0] K_STATUS = 2'd1;
    localparam logic [1:0] K_CONFIG = 2'd2;
    localparam logic [1:0] K_SOFT   = 2'd3;

    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT_BUSY, T_WAIT_DONE} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_GCONF, R_CFG2} rx_state_t;

    tx_state_t     tx_state_reg, tx_state_next;
    rx_state_t     rx_state_reg, rx_state_next;
    logic          run_reg;
    logic [31:0]   shift_reg;
    logic [1:0]    byte_idx_reg;
    logic          is_cmd_reg;
    logic          pending_reg;
    logic [1:0]    pend_kind_reg;
    logic [TW-1:0] tmo_cnt_reg;

    logic cmd_fire, evt_fire, evt_alias, evt_send, frame_last, byte_done;
    logic soft_fire, query_fire;
    logic rx_at_idle, gest_hit, echo_hit, status_hit, cfg_hit, gconf_done, cfg2_done;
    logic reply_hit, tmo_fire;

    assign cmd_fire   = cmd_valid && cmd_ready;
    assign evt_fire   = evt_valid && evt_ready;
    assign evt_alias  = evt_word[31:24] >= 8'hFC;
    assign evt_send   = evt_fire && !evt_alias;
    assign frame_last = is_cmd_reg || (byte_idx_reg == 2'd3);
    assign byte_done  = (tx_state_reg == T_WAIT_DONE) && !tx_busy;
    assign soft_fire  = cmd_fire && (cmd_code == K_SOFT);
    assign query_fire = cmd_fire && (cmd_code != K_SOFT);

    // run_reg keeps both ready outputs low while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg      <= 1'b0;
            tx_state_reg <= T_IDLE;
        end else begin
            run_reg      <= 1'b1;
            tx_state_reg <= tx_state_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            T_IDLE:      if (cmd_fire || evt_send) tx_state_next = T_SEND;
            T_SEND:      tx_state_next = T_WAIT_BUSY;
            T_WAIT_BUSY: if (tx_busy) tx_state_next = T_WAIT_DONE;
            T_WAIT_DONE: if (!tx_busy) tx_state_next = frame_last ? T_IDLE : T_SEND;
            default:     tx_state_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_valid  = (tx_state_reg == T_SEND);
        tx_data   = (tx_state_reg == T_SEND) ? shift_reg[31:24] : 8'h00;
        cmd_ready = run_reg && (tx_state_reg == T_IDLE) && !tx_busy
                    && (!pending_reg || cmd_code == K_SOFT);
        evt_ready = run_reg && (tx_state_reg == T_IDLE) && !tx_busy
                    && !(cmd_valid && cmd_ready);
    end

    // A command byte rides in the top slot of the shift register as a 1-byte frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            byte_idx_reg <= '0;
            is_cmd_reg   <= 1'b0;
        end else if (cmd_fire) begin
            shift_reg    <= {8'hFF - {6'd0, cmd_code}, 24'd0};
            byte_idx_reg <= '0;
            is_cmd_reg   <= 1'b1;
        end else if (evt_send) begin
            shift_reg    <= evt_word;
            byte_idx_reg <= '0;
            is_cmd_reg   <= 1'b0;
        end else if (byte_done && !frame_last) begin
            shift_reg    <= {shift_reg[23:0], 8'h00};
            byte_idx_reg <= byte_idx_reg + 2'd1;
        end
    end

    assign rx_at_idle = rx_valid && (rx_state_reg == R_IDLE);
    assign gest_hit   = rx_at_idle && (rx_data[7:2] == 6'b101000);
    assign echo_hit   = rx_at_idle && !gest_hit && pending_reg
                        && (pend_kind_reg == K_ECHO) && (rx_data == 8'h55);
    assign status_hit = rx_at_idle && !gest_hit && pending_reg
                        && (pend_kind_reg == K_STATUS) && (rx_data[7:4] == 4'hB);
    assign cfg_hit    = rx_at_idle && !gest_hit && pending_reg && (pend_kind_reg == K_CONFIG);
    assign gconf_done = rx_valid && (rx_state_reg == R_GCONF);
    assign cfg2_done  = rx_valid && (rx_state_reg == R_CFG2);
    assign reply_hit  = echo_hit || status_hit || cfg_hit;
    // A reply accepted this cycle beats an expiring counter
    assign tmo_fire   = pending_reg && (rx_state_reg == R_IDLE) && (tmo_cnt_reg == '0) && !reply_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_reg <= R_IDLE;
        else        rx_state_reg <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        if (soft_fire)                   rx_state_next = R_IDLE;
        else if (gest_hit)               rx_state_next = R_GCONF;
        else if (cfg_hit)                rx_state_next = R_CFG2;
        else if (gconf_done || cfg2_done) rx_state_next = R_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gesture           <= '0;
            gesture_conf      <= '0;
            gesture_cnt_hi    <= '0;
            gesture_valid     <= 1'b0;
            echo_ok           <= 1'b0;
            status_byte       <= '0;
            status_valid      <= 1'b0;
            cfg_min_thresh    <= '0;
            cfg_motion_thresh <= '0;
            cfg_valid         <= 1'b0;
        end else begin
            gesture_valid <= gconf_done;
            echo_ok       <= echo_hit;
            status_valid  <= status_hit;
            cfg_valid     <= cfg2_done;
            if (gest_hit) gesture <= rx_data[1:0];
            if (gconf_done) begin
                gesture_conf   <= rx_data[7:4];
                gesture_cnt_hi <= rx_data[3:0];
            end
            if (status_hit) status_byte       <= rx_data;
            if (cfg_hit)    cfg_min_thresh    <= rx_data;
            if (cfg2_done)  cfg_motion_thresh <= rx_data;
        end
    end

    // Countdown pauses while a multi-byte reply is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg   <= 1'b0;
            pend_kind_reg <= '0;
            tmo_cnt_reg   <= '0;
            cmd_timeout   <= 1'b0;
        end else begin
            cmd_timeout <= 1'b0;
            if (soft_fire) begin
                pending_reg <= 1'b0;
                tmo_cnt_reg <= '0;
            end else if (query_fire) begin
                pending_reg   <= 1'b1;
                pend_kind_reg <= cmd_code;
                tmo_cnt_reg   <= TW'(RESP_TIMEOUT);
            end else if (echo_hit || status_hit || cfg2_done) begin
                pending_reg <= 1'b0;
            end else if (tmo_fire) begin
                pending_reg <= 1'b0;
                cmd_timeout <= 1'b1;
            end else if (pending_reg && rx_state_reg == R_IDLE && tmo_cnt_reg != '0) begin
                tmo_cnt_reg <= tmo_cnt_reg - 1'b1;
            end
        end
    end

`ifdef EVT2_STREAM_STATS_EN
    logic [15:0] words_sent_reg, words_dropped_reg, rx_unexp_reg;
    logic        rx_unexp;

    assign rx_unexp = rx_at_idle && !gest_hit && !reply_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_sent_reg    <= '0;
            words_dropped_reg <= '0;
            rx_unexp_reg      <= '0;
        end else begin
            if (byte_done && frame_last && !is_cmd_reg && words_sent_reg != 16'hFFFF)
                words_sent_reg <= words_sent_reg + 16'd1;
            if (evt_fire && evt_alias && words_dropped_reg != 16'hFFFF)
                words_dropped_reg <= words_dropped_reg + 16'd1;
            if (rx_unexp && rx_unexp_reg != 16'hFFFF)
                rx_unexp_reg <= rx_unexp_reg + 16'd1;
        end
    end

    assign stat_words_sent    = words_sent_reg;
    assign stat_words_dropped = words_dropped_reg;
    assign stat_rx_unexpected = rx_unexp_reg;
`else
    assign stat_words_sent    = 16'd0;
    assign stat_words_dropped = 16'd0;
    assign stat_rx_unexpected = 16'd0;
`endif

endmodule

// File: tb/tb_evt2_uart_streamer.sv
// Scoreboard bench for evt2_uart_streamer: directed cases plus randomized
// word/command/reply traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_evt2_uart_streamer;
    localparam int T = 200;
`ifdef EVT2_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] evt_word = '0;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [1:0]  cmd_code = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [1:0]  gesture;
    logic [3:0]  gesture_conf, gesture_cnt_hi;
    logic        gesture_valid, echo_ok, status_valid, cfg_valid, cmd_timeout;
    logic [7:0]  status_byte, cfg_min_thresh, cfg_motion_thresh;
    logic [15:0] stat_words_sent, stat_words_dropped, stat_rx_unexpected;

    always #5 clk = ~clk;

    evt2_uart_streamer #(.RESP_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_word(evt_word), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .cmd_code(cmd_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .gesture(gesture), .gesture_conf(gesture_conf), .gesture_cnt_hi(gesture_cnt_hi),
        .gesture_valid(gesture_valid), .echo_ok(echo_ok),
        .status_byte(status_byte), .status_valid(status_valid),
        .cfg_min_thresh(cfg_min_thresh), .cfg_motion_thresh(cfg_motion_thresh),
        .cfg_valid(cfg_valid), .cmd_timeout(cmd_timeout),
        .stat_words_sent(stat_words_sent), .stat_words_dropped(stat_words_dropped),
        .stat_rx_unexpected(stat_rx_unexpected)
    );

    typedef struct { int kind; int a; int b; int c; } ev_t;  // 0 gest,1 echo,2 status,3 cfg,4 timeout

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_tx[$];
    ev_t         exp_ev[$];
    int          busy_len = 10;
    bit          m_pending = 0;
    int          m_kind = 0, m_phase = 0, m_g = 0, m_min = 0;
    int          m_sent = 0, m_dropped = 0, m_unexp = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endtask

    function automatic int expc(input int m);
        if (!STATS) return 0;
        return (m > 65535) ? 65535 : m;
    endfunction

    task automatic cmp_ev(input int k, input int a, input int b, input int c);
        ev_t e;
        n_checks++;
        if (exp_ev.size() == 0) begin
            $display("FAIL rx_event: got kind %0d (%0h,%0h,%0h), expected none", k, a, b, c);
            return;
        end
        e = exp_ev.pop_front();
        if (e.kind == k && e.a == a && e.b == b && e.c == c) begin
            n_pass++;
            $display("rx event kind %0d (%0h,%0h,%0h) ok", k, a, b, c);
        end else begin
            $display("FAIL rx_event: got kind %0d (%0h,%0h,%0h), expected kind %0d (%0h,%0h,%0h)",
                     k, a, b, c, e.kind, e.a, e.b, e.c);
        end
    endtask

    // Transmitter model: goes busy on the strobe for busy_len cycles
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_valid) begin
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid) begin
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_byte: got 0x%02h, expected no byte", tx_data);
                end else begin
                    $display("tx byte 0x%02h", tx_data);
                    chk("tx_byte", int'(tx_data), int'(exp_tx.pop_front()));
                end
            end
            if (gesture_valid) cmp_ev(0, gesture, gesture_conf, gesture_cnt_hi);
            if (echo_ok)       cmp_ev(1, 0, 0, 0);
            if (status_valid)  cmp_ev(2, status_byte, 0, 0);
            if (cfg_valid)     cmp_ev(3, cfg_min_thresh, cfg_motion_thresh, 0);
            if (cmd_timeout)   cmp_ev(4, 0, 0, 0);
        end
    end

    // Reference model of reply decoding, driven by the bytes the bench sends
    task automatic model_rx(input logic [7:0] b);
        ev_t e;
        if (m_phase == 1) begin
            e = '{0, m_g, int'(b[7:4]), int'(b[3:0])}; exp_ev.push_back(e); m_phase = 0;
        end else if (m_phase == 2) begin
            e = '{3, m_min, int'(b), 0}; exp_ev.push_back(e); m_phase = 0; m_pending = 0;
        end else if (b >= 8'hA0 && b <= 8'hA3) begin
            m_g = int'(b) - 'hA0; m_phase = 1;
        end else if (m_pending && m_kind == 0 && b == 8'h55) begin
            e = '{1, 0, 0, 0}; exp_ev.push_back(e); m_pending = 0;
        end else if (m_pending && m_kind == 1 && b >= 8'hB0 && b <= 8'hBF) begin
            e = '{2, int'(b), 0, 0}; exp_ev.push_back(e); m_pending = 0;
        end else if (m_pending && m_kind == 2) begin
            m_min = int'(b); m_phase = 2;
        end else begin
            m_unexp++;
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        model_rx(b);
        @(negedge clk);
        rx_valid = 1'b0; rx_data = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        evt_word = w; evt_valid = 1'b1; #1;
        while (!evt_ready && n < 2000) begin @(negedge clk); #1; n++; end
        if (!evt_ready) begin
            fail_bound("evt_handshake");
        end else if (w[31:24] >= 8'hFC) begin
            m_dropped++;
        end else begin
            for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
            m_sent++;
        end
        @(posedge clk); #1;
        evt_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        int n = 0;
        @(negedge clk);
        cmd_code = c; cmd_valid = 1'b1; #1;
        while (!cmd_ready && n < 2000) begin @(negedge clk); #1; n++; end
        if (!cmd_ready) begin
            fail_bound("cmd_handshake");
        end else begin
            exp_tx.push_back(8'hFF - {6'd0, c});
            if (c == 2'd3) begin m_pending = 0; m_phase = 0; end
            else begin m_pending = 1; m_kind = int'(c); end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk); #1;
        while ((exp_tx.size() != 0 || tx_busy) && n < 1000) begin @(negedge clk); #1; n++; end
        if (n >= 1000) fail_bound("tx_drain");
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_words_sent"}, int'(stat_words_sent), expc(m_sent));
        chk({tag, "_words_dropped"}, int'(stat_words_dropped), expc(m_dropped));
        chk({tag, "_rx_unexpected"}, int'(stat_rx_unexpected), expc(m_unexp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] w;
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("reset_evt_ready", int'(evt_ready), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        chk("reset_tx_valid", int'(tx_valid), 0);
        chk("reset_status_byte", int'(status_byte), 0);
        chk("reset_cfg_min", int'(cfg_min_thresh), 0);
        chk("reset_strobes", int'({gesture_valid, echo_ok, status_valid, cfg_valid, cmd_timeout}), 0);
        check_stats("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_reset_evt_ready", int'(evt_ready), 1);

        // Plain word with 10-cycle busy per byte
        busy_len = 10;
        send_word(32'h1234ABCD);
        drain();
        check_stats("word1");

        // Reset mid-frame: the rest of the word is lost
        send_word(32'h11223344);
        n = 0;
        while (exp_tx.size() != 3 && n < 200) begin @(negedge clk); #1; n++; end
        if (n >= 200) fail_bound("midframe_first_byte");
        @(negedge clk);
        rst_n = 1'b0;
        exp_tx.delete();
        m_sent = 0; m_dropped = 0; m_unexp = 0; m_pending = 0; m_phase = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("midframe_reset_sent", int'(stat_words_sent), 0);
        rst_n = 1'b1;
        drain();
        repeat (20) @(negedge clk);

        // Status command wins over a simultaneous word
        @(negedge clk);
        cmd_code = 2'd1; cmd_valid = 1'b1; evt_word = 32'hCAFE0123; evt_valid = 1'b1; #1;
        chk("prio_cmd_ready", int'(cmd_ready), 1);
        chk("prio_evt_ready", int'(evt_ready), 0);
        exp_tx.push_back(8'hFE);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(evt_word[i*8 +: 8]);
        m_pending = 1; m_kind = 1; m_sent++;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        @(negedge clk); #1;
        while (!evt_ready && n < 500) begin @(negedge clk); #1; n++; end
        if (!evt_ready) fail_bound("prio_evt_handshake");
        @(posedge clk); #1;
        evt_valid = 1'b0;
        drain();
        send_rx(8'hB4);
        chk("status_byte_b4", int'(status_byte), 'hB4);

        // Aliasing word is swallowed
        send_word(32'hFD000000);
        drain();
        check_stats("drop");

        // Config query
        send_cmd(2'd2);
        drain();
        send_rx(8'h14);
        send_rx(8'h08);
        chk("cfg_min", int'(cfg_min_thresh), 'h14);
        chk("cfg_motion", int'(cfg_motion_thresh), 'h08);

        // Unsolicited gesture report
        send_rx(8'hA2);
        send_rx(8'h93);
        chk("gesture", int'(gesture), 2);
        chk("gesture_conf", int'(gesture_conf), 9);
        chk("gesture_cnt_hi", int'(gesture_cnt_hi), 3);

        // Echo with no reply times out
        exp_ev.push_back('{4, 0, 0, 0});
        send_cmd(2'd0);
        n = 0;
        while (!cmd_timeout && n < T + 50) begin @(negedge clk); n++; end
        if (!cmd_timeout) fail_bound("echo_timeout");
        m_pending = 0;
        chk("timeout_latency_in_window", int'(n >= T && n <= T + 2), 1);
        @(negedge clk); #1;
        chk("cmd_ready_after_timeout", int'(cmd_ready), 1);
        send_rx(8'h55);
        repeat (2) @(negedge clk);
        check_stats("timeout");

        // Soft-reset cancels a pending status query
        send_cmd(2'd1);
        drain();
        @(negedge clk);
        cmd_code = 2'd0; cmd_valid = 1'b1; #1;
        chk("cmd_ready_blocked_pending", int'(cmd_ready), 0);
        cmd_code = 2'd3; #1;
        chk("cmd_ready_soft_reset", int'(cmd_ready), 1);
        cmd_valid = 1'b0;
        send_cmd(2'd3);
        drain();
        send_rx(8'hB5);
        repeat (2) @(negedge clk);
        check_stats("soft");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            busy_len = $urandom_range(2, 12);
            case ($urandom_range(0, 6))
                0, 1, 2: begin
                    w = $urandom;
                    if ($urandom_range(0, 4) == 0) w[31:24] = 8'($urandom_range(252, 255));
                    send_word(w);
                end
                3: begin
                    n = $urandom_range(0, 2);
                    send_cmd(2'(n));
                    drain();
                    if (n == 0)      send_rx(8'h55);
                    else if (n == 1) send_rx(8'hB0 | 8'($urandom_range(0, 15)));
                    else begin
                        send_rx(8'($urandom_range(0, 159)));
                        send_rx(8'($urandom_range(0, 255)));
                    end
                end
                4: begin
                    send_rx(8'hA0 + 8'($urandom_range(0, 3)));
                    send_rx(8'($urandom_range(0, 255)));
                end
                5: send_rx(8'($urandom_range(0, 159)));
                default: send_cmd(2'd3);
            endcase
        end
        drain();
        check_stats("final");
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("event_queue_empty", exp_ev.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/evt2_uart_streamer.md
# evt2_uart_streamer

Host-side counterpart of the voxel-bin classifier's UART link. Accepts 32-bit EVT2.0 words on a valid/ready port and serialises them MSB-first onto a byte-wide `uart_tx` interface. Injects control commands (echo, status, config, soft-reset) only at word boundaries. Decodes the classifier's reply bytes (gesture reports, echo, status, config) arriving on a byte-wide `uart_rx` interface. Sits between an event-camera/replay source and the `uart_tx`/`uart_rx` instances on the host FPGA.

## Interface
- `RESP_TIMEOUT`, 120000: cycles allowed for a query reply before it is abandoned (must be ≥ 1).
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `evt_word`  in  32  EVT2.0 word.
- `evt_valid` / `evt_ready`  in/out  1  word handshake; transfer on `evt_valid && evt_ready`.
- `cmd_code`  in  2  command: 0=echo (0xFF), 1=status (0xFE), 2=config (0xFD), 3=soft-reset (0xFC).
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  one-cycle send strobe.
- `tx_busy`  in  1  transmitter busy.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle receive strobe.
- `gesture`  out  2  decoded gesture class.
- `gesture_conf`  out  4  decoded confidence.
- `gesture_cnt_hi`  out  4  decoded event-count nibble.
- `gesture_valid`  out  1  one-cycle report strobe.
- `echo_ok`  out  1  one-cycle pulse on reply 0x55.
- `status_byte`  out  8  received status byte.
- `status_valid`  out  1  one-cycle status strobe.
- `cfg_min_thresh`  out  8  first config reply byte.
- `cfg_motion_thresh`  out  8  second config reply byte.
- `cfg_valid`  out  1  one-cycle config strobe.
- `cmd_timeout`  out  1  one-cycle pulse when a pending query expires.
- `stat_words_sent`, `stat_words_dropped`, `stat_rx_unexpected`  out  16 each  counters; see Configuration.

## Operation
- TX FSM states: `T_IDLE`, `T_SEND`, `T_WAIT_BUSY`, `T_WAIT_DONE`.
  - `byte_idx` (2 bits) and a 32-bit shift register hold the frame being sent.
  - `T_IDLE`: leaves only when `tx_busy`=0.
  - Frame selection priority:
    1. A command, when `cmd_valid && cmd_ready`: 1-byte frame.
    2. Otherwise a word, when `evt_valid && evt_ready`.
  - `T_SEND`: drives `tx_valid`=1 with the current byte for one cycle, then goes to `T_WAIT_BUSY`.
  - `T_WAIT_BUSY`: waits for `tx_busy`=1, then goes to `T_WAIT_DONE`.
  - `T_WAIT_DONE`: waits for `tx_busy`=0. Next byte → `T_SEND`; last byte → `T_IDLE`.
- `evt_ready` = `T_IDLE && !tx_busy && !(cmd_valid && cmd_ready)`.
- `cmd_ready` = `T_IDLE && !tx_busy && no query pending`. Soft-reset is always accepted in `T_IDLE` with `tx_busy`=0.
- Words are never split; commands only ever occupy the first byte slot of a frame.
- Word with `evt_word[31:24]` ≥ 0xFC (it would alias a command byte):
  - Accepted but not transmitted.
  - FSM stays in `T_IDLE`.
  - `stat_words_dropped` increments.
- Echo/status/config set one `pending` flag (2-bit kind) and load the timeout counter with `RESP_TIMEOUT`.
- Soft-reset clears `pending`, the RX FSM, and the timeout, and expects no reply.
- RX FSM states: `R_IDLE`, `R_GCONF`, `R_CFG2`. On each `rx_valid` in `R_IDLE`:
  - 0xA0–0xA3: latch `gesture`=byte[1:0] → `R_GCONF`.
  - 0x55 with echo pending: pulse `echo_ok`, clear pending.
  - 0xB0–0xBF with status pending: latch `status_byte`, pulse `status_valid`, clear pending.
  - Any other byte with config pending: latch `cfg_min_thresh` → `R_CFG2`.
  - Anything else: `stat_rx_unexpected`++.
- In `R_GCONF`: any byte sets `gesture_conf`=byte[7:4] and `gesture_cnt_hi`=byte[3:0], pulses `gesture_valid`, returns to `R_IDLE`.
- In `R_CFG2`: any byte latches `cfg_motion_thresh`, pulses `cfg_valid`, clears pending, returns to `R_IDLE`.
- Timeout:
  - Counts down only while `pending` is set and the RX FSM is in `R_IDLE`.
  - At 0: pulse `cmd_timeout`, clear pending.
  - A reply byte that completes the pending query in the same cycle wins over the timeout.

## Timing
- Reset values:
  - All strobes 0; `evt_ready`=0 and `cmd_ready`=0 during reset.
  - All data outputs and counters 0.
  - Both FSMs idle; no query pending.
- Word accepted at cycle N: `tx_valid`=1 with byte [31:24] at N+1. Each following byte is sent one cycle after `tx_busy` falls.
- Reply decode latency: strobes assert the cycle after the final reply byte's `rx_valid`.
- `rst_n` deasserted mid-frame: remaining bytes are lost, and no partial word is resumed.

## Configuration
- `EVT2_STREAM_STATS_EN` defined: the three counters are live, 16-bit, saturating at 0xFFFF. `stat_words_sent` increments when a word's last byte completes.
- Not defined: counters are tied to 0 and their registers are absent. Dropping and decoding are unchanged.

## Test plan
- Word 0x1234ABCD with `tx_busy` modelled as a 10-cycle busy per byte → `tx_data` sequence 0x12, 0x34, 0xAB, 0xCD, each with a one-cycle `tx_valid`; `stat_words_sent`=1.
- `cmd_valid` (status) and `evt_valid` asserted together in `T_IDLE` → 0xFE sent first; reply 0xB4 → `status_valid`, `status_byte`=0xB4; the word is sent next.
- Word 0xFD000000 → accepted, nothing transmitted, `stat_words_dropped`=1.
- Config query, reply 0x14 then 0x08 → `cfg_valid`, `cfg_min_thresh`=0x14, `cfg_motion_thresh`=0x08.
- Reply 0xA2 then 0x93 with no pending query → `gesture_valid`, `gesture`=2, `gesture_conf`=9, `gesture_cnt_hi`=3.
- Echo query with no reply for `RESP_TIMEOUT` cycles → `cmd_timeout` pulses once and `cmd_ready` returns to 1; a later 0x55 → `stat_rx_unexpected`=1.
